// File: rtl/color_sensor_filter.sv
// Debounces the edge/corner colour sensors after each move sequence: settle, then require a
// run of identical valid samples, with a flagged timeout fallback.
module color_sensor_filter #(
    parameter int unsigned SETTLE_CYCLES  = 2_000_000,
    parameter int unsigned STABLE_COUNT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 8_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] edge_raw,
    input  logic [2:0] corner_raw,
    input  logic       raw_valid,
    input  logic       moves_done,
    output logic [2:0] edge_color_sensor,
    output logic [2:0] corner_color_sensor,
    output logic       color_sensor_stable,
    output logic       sensor_timeout,
    output logic [5:0] obs_count
);

    localparam int unsigned SettleW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned RunW     = $clog2(STABLE_COUNT + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SettleW-1:0]  SettleLoad = SettleW'(SETTLE_CYCLES);
    localparam logic [RunW-1:0]     RunMax     = RunW'(STABLE_COUNT);
    localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StSample} state_t;

    state_t              r_state;
    logic [SettleW-1:0]  r_settle_cnt;
    logic [RunW-1:0]     r_run;
    logic [TimeoutW-1:0] r_to_cnt;
    logic [2:0]          r_cand_edge;
    logic [2:0]          r_cand_corner;
    logic [2:0]          r_edge_out;
    logic [2:0]          r_corner_out;
    logic                r_stable;
    logic                r_timeout;
    logic [5:0]          r_obs;

    logic                w_edge_ok;
    logic                w_corner_ok;
    logic [RunW-1:0]     w_run;
    logic [2:0]          w_cand_edge;
    logic [2:0]          w_cand_corner;
    logic                w_done_stable;
    logic                w_done_timeout;

    assign w_edge_ok   = (edge_raw <= 3'd5);
    assign w_corner_ok = (corner_raw <= 3'd5);

    // Next candidate/run including this cycle's sample, so a completing or timing-out
    // cycle latches the freshest candidates.
    always_comb begin
        w_run         = r_run;
        w_cand_edge   = r_cand_edge;
        w_cand_corner = r_cand_corner;
        if (raw_valid) begin
            if (!(w_edge_ok && w_corner_ok)) begin
                w_cand_edge   = 3'd7;
                w_cand_corner = 3'd7;
                w_run         = '0;
            end else if (edge_raw == r_cand_edge && corner_raw == r_cand_corner) begin
                if (r_run != RunMax) begin
                    w_run = r_run + RunW'(1);
                end
            end else begin
                w_cand_edge   = edge_raw;
                w_cand_corner = corner_raw;
                w_run         = RunW'(1);
            end
        end
        w_done_stable  = (w_run == RunMax);
        w_done_timeout = ((r_to_cnt + TimeoutW'(1)) == TimeoutMax);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_settle_cnt  <= '0;
            r_run         <= '0;
            r_to_cnt      <= '0;
            r_cand_edge   <= 3'd7;
            r_cand_corner <= 3'd7;
            r_edge_out    <= 3'd0;
            r_corner_out  <= 3'd0;
            r_stable      <= 1'b0;
            r_timeout     <= 1'b0;
            r_obs         <= 6'd0;
        end else begin
            r_stable <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (moves_done) begin
                        r_state      <= StSettle;
                        r_settle_cnt <= SettleLoad;
                    end
                end
                StSettle: begin
                    if (moves_done) begin
                        r_settle_cnt <= SettleLoad;
                    end else if (r_settle_cnt == SettleW'(1)) begin
                        r_state       <= StSample;
                        r_run         <= '0;
                        r_to_cnt      <= '0;
                        r_cand_edge   <= 3'd7;
                        r_cand_corner <= 3'd7;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SettleW'(1);
                    end
                end
                StSample: begin
                    if (w_done_stable || w_done_timeout) begin
                        r_edge_out   <= w_cand_edge;
                        r_corner_out <= w_cand_corner;
                        r_timeout    <= !w_done_stable;
                        r_stable     <= 1'b1;
                        r_obs        <= r_obs + 6'd1;
                        r_state      <= StIdle;
                    end else begin
                        r_run         <= w_run;
                        r_cand_edge   <= w_cand_edge;
                        r_cand_corner <= w_cand_corner;
                        r_to_cnt      <= r_to_cnt + TimeoutW'(1);
                    end
                    // A new move sequence overrides both completion and continued sampling.
                    if (moves_done) begin
                        r_state      <= StSettle;
                        r_settle_cnt <= SettleLoad;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign edge_color_sensor   = r_edge_out;
    assign corner_color_sensor = r_corner_out;
    assign color_sensor_stable = r_stable;
    assign sensor_timeout      = r_timeout;
    assign obs_count           = r_obs;

endmodule
